ibfly2_seq: RTL and testbench

- Sequential radix-2 inverse butterfly. It undoes the DIT butterfly: given y0 = x0 + w·x1 and y1 = x0 − w·x1, it recovers x0 = (y0+y1)/2 and x1 = conj(w)·(y0−y1)/2.
- It uses one shared signed multiplier, time-multiplexed over four cycles, with valid/ready handshakes on both sides.
- It is the building block of the IFFT/verification path that sits after the DIT butterfly stages.

---
 rtl/ibfly2_seq.sv | 200 ++++++++++++++++++++
 tb/tb_ibfly2_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibfly2_seq.sv
// ---------------------------------------------------------------------------
// ibfly2_seq -- sequential radix-2 inverse butterfly.
//
// Undoes a DIT butterfly y0 = x0 + w*x1, y1 = x0 - w*x1 by computing
//   x0 = (y0 + y1) / 2              (floor)
//   x1 = conj(w) * (y0 - y1) / 2    (round half up)
// with one shared signed multiplier used over four cycles (M0..M3).
// An operation is accepted in IDLE, out_valid rises six edges later and the
// result is held in DONE until the consumer takes it.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   yr0, yi0, yr1, yi1    signed DW-bit butterfly outputs to invert
//   wr0, wi0              signed TW-bit twiddle, Q1.(TW-2), not conjugated
//   out_valid / out_ready result handshake
//   xr0, xi0, xr1, xi1    signed DW-bit recovered inputs
//   ovf                   x1 was clamped on this result
//
// Build option:
//   IBFLY2_SAT_EN  defined   -> x1 clamped to the DW-bit range, ovf reports it
//                  undefined -> x1 wraps to the low DW bits, ovf stays 0
// ---------------------------------------------------------------------------
module ibfly2_seq #(
    parameter int DW = 8,
    parameter int TW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] yr0,
    input  logic signed [DW-1:0] yi0,
    input  logic signed [DW-1:0] yr1,
    input  logic signed [DW-1:0] yi1,
    input  logic signed [TW-1:0] wr0,
    input  logic signed [TW-1:0] wi0,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] xr0,
    output logic signed [DW-1:0] xi0,
    output logic signed [DW-1:0] xr1,
    output logic signed [DW-1:0] xi1,
    output logic                 ovf
);

    localparam int ACCW = DW + TW + 2;   // two products of (DW+1) x TW bits
    localparam int PW   = DW + TW + 1;   // one product

    // Half an output LSB at the accumulator scale: x1 = acc / 2^(TW-1).
    localparam logic signed [ACCW-1:0] HALF = ACCW'(2 ** (TW - 2));

    typedef enum logic [2:0] {
        S_IDLE, S_SUM, S_M0, S_M1, S_M2, S_M3, S_RND, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic signed [DW-1:0]   yr0_q, yi0_q, yr1_q, yi1_q;
    logic signed [TW-1:0]   wr_q, wi_q;
    logic signed [DW:0]     dr_q, di_q;
    logic signed [ACCW-1:0] acc_r, acc_i;

    logic signed [DW:0]     sum_r, sum_i, diff_r, diff_i;
    logic signed [DW:0]     mul_a;
    logic signed [TW-1:0]   mul_b;
    logic signed [PW-1:0]   prod;
    logic signed [ACCW-1:0] prod_ext;
    logic signed [DW-1:0]   x1r_nxt, x1i_nxt;
    logic                   ovf_nxt;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_SUM;
            S_SUM:   state_nxt = S_M0;
            S_M0:    state_nxt = S_M1;
            S_M1:    state_nxt = S_M2;
            S_M2:    state_nxt = S_M3;
            S_M3:    state_nxt = S_RND;
            S_RND:   state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_DONE);
    end

    // ---------------- datapath: combinational ----------------
    always_comb begin
        sum_r  = {yr0_q[DW-1], yr0_q} + {yr1_q[DW-1], yr1_q};
        sum_i  = {yi0_q[DW-1], yi0_q} + {yi1_q[DW-1], yi1_q};
        diff_r = {yr0_q[DW-1], yr0_q} - {yr1_q[DW-1], yr1_q};
        diff_i = {yi0_q[DW-1], yi0_q} - {yi1_q[DW-1], yi1_q};
    end

    // Shared multiplier operand schedule:
    //   M0 dr*wr -> accR   M1 di*wi -> accR   M2 di*wr -> accI   M3 dr*wi -> accI (sub)
    always_comb begin
        mul_a = dr_q;
        mul_b = wr_q;
        case (state)
            S_M1:    begin mul_a = di_q; mul_b = wi_q; end
            S_M2:    begin mul_a = di_q; mul_b = wr_q; end
            S_M3:    begin mul_a = dr_q; mul_b = wi_q; end
            default: ;
        endcase
        // Both operands sign-extended to the full product width, so the low
        // PW bits of the product are the exact signed result.
        prod     = {{TW{mul_a[DW]}}, mul_a} * {{(DW + 1){mul_b[TW-1]}}, mul_b};
        prod_ext = {prod[PW-1], prod};
    end

`ifdef IBFLY2_SAT_EN
    localparam logic signed [ACCW-1:0] X_MAX = ACCW'(2 ** (DW - 1) - 1);
    localparam logic signed [ACCW-1:0] X_MIN = ~X_MAX;

    logic signed [ACCW-1:0] rnd_r, rnd_i;
    logic                   ovf_r, ovf_i;

    // Returns {clamped, value} for one rounded x1 component.
    function automatic logic [DW:0] clamp(input logic signed [ACCW-1:0] v);
        if (v > X_MAX)      clamp = {1'b1, X_MAX[DW-1:0]};
        else if (v < X_MIN) clamp = {1'b1, X_MIN[DW-1:0]};
        else                clamp = {1'b0, v[DW-1:0]};
    endfunction

    always_comb begin
        rnd_r              = (acc_r + HALF) >>> (TW - 1);
        rnd_i              = (acc_i + HALF) >>> (TW - 1);
        {ovf_r, x1r_nxt}   = clamp(rnd_r);
        {ovf_i, x1i_nxt}   = clamp(rnd_i);
        ovf_nxt            = ovf_r | ovf_i;
    end
`else
    // Wrapping build: keep the low DW bits of the rounded value.
    always_comb begin
        x1r_nxt = DW'((acc_r + HALF) >>> (TW - 1));
        x1i_nxt = DW'((acc_i + HALF) >>> (TW - 1));
        ovf_nxt = 1'b0;
    end
`endif

    // ---------------- datapath: registers ----------------
    // NOTE: every datapath register is reset as well, so a reset in the middle
    // of an operation leaves nothing behind that could leak into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            yr0_q <= '0; yi0_q <= '0; yr1_q <= '0; yi1_q <= '0;
            wr_q  <= '0; wi_q  <= '0;
            dr_q  <= '0; di_q  <= '0;
            acc_r <= '0; acc_i <= '0;
            xr0   <= '0; xi0   <= '0; xr1 <= '0; xi1 <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (in_valid) begin
                    yr0_q <= yr0; yi0_q <= yi0;
                    yr1_q <= yr1; yi1_q <= yi1;
                    wr_q  <= wr0; wi_q  <= wi0;
                    ovf   <= 1'b0;
                end
                S_SUM: begin
                    dr_q  <= diff_r;
                    di_q  <= diff_i;
                    // Arithmetic shift floors; the halved sum always fits DW.
                    xr0   <= DW'(sum_r >>> 1);
                    xi0   <= DW'(sum_i >>> 1);
                    acc_r <= '0;
                    acc_i <= '0;
                end
                S_M0, S_M1: acc_r <= acc_r + prod_ext;
                S_M2:       acc_i <= acc_i + prod_ext;
                S_M3:       acc_i <= acc_i - prod_ext;
                S_RND: begin
                    xr1 <= x1r_nxt;
                    xi1 <= x1i_nxt;
                    ovf <= ovf_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ibfly2_seq.sv
// ---------------------------------------------------------------------------
// tb_ibfly2_seq -- self-checking bench for ibfly2_seq.
// Directed vectors from a table, hand-written backpressure and mid-operation
// reset sequences, then a random stream compared with a real-arithmetic
// reference model and a forward-butterfly round trip.
// Honours IBFLY2_SAT_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_ibfly2_seq;

    localparam int DW = 8;
    localparam int TW = 8;

    logic                 clk, rst_n;
    logic                 in_valid, in_ready, out_valid, out_ready, ovf;
    logic signed [DW-1:0] yr0, yi0, yr1, yi1;
    logic signed [TW-1:0] wr0, wi0;
    logic signed [DW-1:0] xr0, xi0, xr1, xi1;

    int n_checks = 0;
    int n_err    = 0;
    int pos_cnt  = 0;

    typedef struct {
        string name;
        int yr0, yi0, yr1, yi1, wr, wi;
        int xr0, xi0, xr1, xi1, ovf;
    } vec_t;

    typedef struct {
        int xr0, xi0, xr1, xi1, ovf;
    } res_t;

    ibfly2_seq #(.DW(DW), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .yr0(yr0), .yi0(yi0), .yr1(yr1), .yi1(yi1),
        .wr0(wr0), .wi0(wi0),
        .out_valid(out_valid), .out_ready(out_ready),
        .xr0(xr0), .xi0(xi0), .xr1(xr1), .xi1(xi1),
        .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) pos_cnt <= pos_cnt + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input int yr0_v, yi0_v, yr1_v, yi1_v,
                                input int wr_v, wi_v, xr0_v, xi0_v, xr1_v, xi1_v, ovf_v);
        vec_t v;
        v.name = name;
        v.yr0 = yr0_v; v.yi0 = yi0_v; v.yr1 = yr1_v; v.yi1 = yi1_v;
        v.wr = wr_v; v.wi = wi_v;
        v.xr0 = xr0_v; v.xi0 = xi0_v; v.xr1 = xr1_v; v.xi1 = xi1_v; v.ovf = ovf_v;
        return v;
    endfunction

    // Reduction of one rounded x1 component to DW bits.
    function automatic int fit(input int v, output int ov);
`ifdef IBFLY2_SAT_EN
        ov = (v > 127 || v < -128) ? 1 : 0;
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
`else
        int m;
        ov = 0;
        m = ((v % 256) + 256) % 256;
        return (m >= 128) ? m - 256 : m;
`endif
    endfunction

    // Reference: x0 = floor((y0+y1)/2); x1 = round-half-up(conj(w)*(y0-y1) / (2*64)).
    function automatic res_t model(input int yr0_v, yi0_v, yr1_v, yi1_v, wr_v, wi_v);
        res_t r;
        int dr, di, qr, qi, ovr, ovi;
        r.xr0 = $rtoi($floor((yr0_v + yr1_v) / 2.0));
        r.xi0 = $rtoi($floor((yi0_v + yi1_v) / 2.0));
        dr = yr0_v - yr1_v;
        di = yi0_v - yi1_v;
        qr = $rtoi($floor((dr * wr_v + di * wi_v) / 128.0 + 0.5));
        qi = $rtoi($floor((di * wr_v - dr * wi_v) / 128.0 + 0.5));
        r.xr1 = fit(qr, ovr);
        r.xi1 = fit(qi, ovi);
        r.ovf = ovr | ovi;
        return r;
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic drive(input int yr0_v, yi0_v, yr1_v, yi1_v, wr_v, wi_v);
        yr0 = DW'(yr0_v); yi0 = DW'(yi0_v);
        yr1 = DW'(yr1_v); yi1 = DW'(yi1_v);
        wr0 = TW'(wr_v);  wi0 = TW'(wi_v);
    endtask

    task automatic check_res(input string tag, input int exr0, exi0, exr1, exi1, eovf);
        check({tag, "_xr0"}, xr0, exr0);
        check({tag, "_xi0"}, xi0, exi0);
        check({tag, "_xr1"}, xr1, exr1);
        check({tag, "_xi1"}, xi1, exi1);
        check({tag, "_ovf"}, ovf, eovf);
    endtask

    // Called at a negedge with the DUT idle. Returns at the negedge where
    // out_valid is first seen (or after a bounded wait); lat is counted in
    // edges from the accept edge, busy_ok reports in_ready stayed low.
    task automatic run_op(input vec_t v, output int lat, output int busy_ok);
        int acc_edge;
        drive(v.yr0, v.yi0, v.yr1, v.yi1, v.wr, v.wi);
        in_valid = 1'b1;
        acc_edge = pos_cnt + 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        busy_ok  = 1;
        lat      = -1;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) busy_ok = 0;
            if (out_valid) begin
                lat = pos_cnt - acc_edge;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t tbl[5];
    int   lat, busy_ok, flag;
    logic signed [DW-1:0] snap_r0, snap_i0, snap_r1, snap_i1;
    logic                 snap_ovf;

    initial begin
        tbl[0] = mk("ident",   10,   4,    6,   -2,   64,    0,  8,  1,  2,  3, 0);
        tbl[1] = mk("quarter",  3,   5,    1,    1,    0,   64,  2,  3,  2, -1, 0);
`ifdef IBFLY2_SAT_EN
        tbl[2] = mk("ovf_neg", 127, 127, -128, -128, -128, -128, -1, -1, -128, 0, 1);
        tbl[3] = mk("ovf_pos", 127, 127, -128, -128,  127,  127, -1, -1,  127, 0, 1);
`else
        tbl[2] = mk("ovf_neg", 127, 127, -128, -128, -128, -128, -1, -1,    2, 0, 0);
        tbl[3] = mk("ovf_pos", 127, 127, -128, -128,  127,  127, -1, -1,   -6, 0, 0);
`endif
        tbl[4] = mk("neg_half", -3,  0,    0,    0,   64,    0, -2,  0, -1,  0, 0);

        // ---------------- reset state ----------------
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #3;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check_res("rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) flag = 0;
        end
        check("idle_quiet", flag, 1);

        // ---------------- directed table ----------------
        out_ready = 1'b1;
        foreach (tbl[i]) begin
            run_op(tbl[i], lat, busy_ok);
            check({tbl[i].name, "_lat"}, lat, 6);
            check({tbl[i].name, "_busy"}, busy_ok, 1);
            check_res(tbl[i].name, tbl[i].xr0, tbl[i].xi0, tbl[i].xr1, tbl[i].xi1, tbl[i].ovf);
            @(negedge clk);
            check({tbl[i].name, "_ov_drop"}, out_valid, 0);
            check({tbl[i].name, "_ready_back"}, in_ready, 1);
        end

        // ---------------- backpressure ----------------
        out_ready = 1'b0;
        run_op(tbl[0], lat, busy_ok);
        check("bp_lat", lat, 6);
        check_res("bp", 8, 1, 2, 3, 0);
        snap_r0 = xr0; snap_i0 = xi0; snap_r1 = xr1; snap_i1 = xi1; snap_ovf = ovf;
        flag = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!out_valid || in_ready || xr0 !== snap_r0 || xi0 !== snap_i0 ||
                xr1 !== snap_r1 || xi1 !== snap_i1 || ovf !== snap_ovf) flag = 0;
            in_valid = (k % 2 == 0);
            drive(int'($urandom_range(255)) - 128, 7, -9, 11, 64, 0);
        end
        check("bp_hold", flag, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_ov_drop", out_valid, 0);
        check("bp_ready_back", in_ready, 1);
        run_op(tbl[1], lat, busy_ok);
        check("bp2_lat", lat, 6);
        check_res("bp2", 2, 3, 2, -1, 0);
        @(negedge clk);

        // ---------------- reset during M2 ----------------
        drive(tbl[0].yr0, tbl[0].yi0, tbl[0].yr1, tbl[0].yi1, tbl[0].wr, tbl[0].wi);
        in_valid = 1'b1;
        @(posedge clk);               // accept
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);    // SUM, M0, M1 done: now in M2
        check("pre_rst_xr0", xr0, 8);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check_res("mid_rst", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        flag = 1;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) flag = 0;
        end
        check("post_rst_quiet", flag, 1);
        run_op(tbl[1], lat, busy_ok);
        check("post_rst_lat", lat, 6);
        check_res("post_rst", 2, 3, 2, -1, 0);
        @(negedge clk);

        // ---------------- random stream ----------------
        // First 20: axis twiddles built from known x (round-trip check);
        // the rest: arbitrary full-range y and w against the model only.
        in_valid = 1'b1;
        for (int n = 0; n < 32; n++) begin
            int x0r, x0i, x1r, x1i, w_r, w_i, y0r, y0i, y1r, y1i, pr, pi, acc_edge;
            res_t e;
            if (n < 20) begin
                x0r = int'($urandom_range(120)) - 60; x0i = int'($urandom_range(120)) - 60;
                x1r = int'($urandom_range(120)) - 60; x1i = int'($urandom_range(120)) - 60;
                case ($urandom_range(3))
                    0:       begin w_r =  64; w_i =   0; end
                    1:       begin w_r =   0; w_i =  64; end
                    2:       begin w_r = -64; w_i =   0; end
                    default: begin w_r =   0; w_i = -64; end
                endcase
                pr  = (w_r * x1r - w_i * x1i) / 64;
                pi  = (w_r * x1i + w_i * x1r) / 64;
                y0r = x0r + pr; y0i = x0i + pi;
                y1r = x0r - pr; y1i = x0i - pi;
            end else begin
                x0r = 0; x0i = 0; x1r = 0; x1i = 0;
                y0r = int'($urandom_range(255)) - 128; y0i = int'($urandom_range(255)) - 128;
                y1r = int'($urandom_range(255)) - 128; y1i = int'($urandom_range(255)) - 128;
                w_r = int'($urandom_range(255)) - 128; w_i = int'($urandom_range(255)) - 128;
            end
            e = model(y0r, y0i, y1r, y1i, w_r, w_i);
            check("stream_ready", in_ready, 1);
            drive(y0r, y0i, y1r, y1i, w_r, w_i);
            acc_edge = pos_cnt + 1;
            lat = -1;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (out_valid) begin
                    lat = pos_cnt - acc_edge;
                    break;
                end
            end
            check("stream_lat", lat, 6);
            check_res("stream", e.xr0, e.xi0, e.xr1, e.xi1, e.ovf);
            if (n < 20) begin
                check("rt_xr0", absdiff(xr0, x0r) <= 1, 1);
                check("rt_xi0", absdiff(xi0, x0i) <= 1, 1);
                check("rt_xr1", absdiff(xr1, x1r) <= 1, 1);
                check("rt_xi1", absdiff(xi1, x1i) <= 1, 1);
            end
            @(negedge clk);           // handshake edge has passed: back in IDLE
        end
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("end_idle", in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
